rc_bit_unstuff: RTL

RC_BIT_UNSTUFF -- requirements
Module: rc_bit_unstuff

---
 rtl/rc_bit_unstuff.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rc_bit_unstuff.sv
`default_nettype none
// ============================================================================
//  Module      : rc_bit_unstuff
//  Description : Receive-side bit unstuffer. Drops the 0 inserted after six
//                consecutive 1s, forwards every other bit to the receive CRC
//                stage with one clock of latency, frames the packet with
//                start/end pulses, and flags stuffing and length errors.
//  Revision    : 1.0  initial release
// ============================================================================
module rc_bit_unstuff (
    input  logic clk,
    input  logic rst_n,
    input  logic abort,
    input  logic d_in,
    input  logic d_valid,
    input  logic sop,
    input  logic eop,
    input  logic err_ack,
    output logic s_in,
    output logic s_valid,
    output logic start_rc_crc,
    output logic end_rc_crc,
    output logic stuff_err,
    output logic len_err
);

    // Largest number of unstuffed bits a packet may carry.
    localparam logic [6:0] MAX_BITS  = 7'd88;
    // Run length of 1s after which the next bit must be a stuffed 0.
    localparam logic [2:0] ONES_STUF = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t     state_q,     state_d;
    logic [2:0] ones_q,      ones_d;
    logic [6:0] cnt_q,       cnt_d;
    logic       s_in_q,      s_in_d;
    logic       s_valid_q,   s_valid_d;
    logic       start_q,     start_d;
    logic       end_q,       end_d;
    logic       stuff_err_q, stuff_err_d;
    logic       len_err_q,   len_err_d;

    // Per-cycle decode helpers: an error raised by the bit in this cycle,
    // and whether that bit is being forwarded.
    logic       bit_err;
    logic       fwd;

    // Next-state and next-output computation for the whole block.
    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        s_in_d      = 1'b0;
        s_valid_d   = 1'b0;
        start_d     = 1'b0;
        end_d       = 1'b0;
        stuff_err_d = stuff_err_q;
        len_err_d   = len_err_q;
        bit_err     = 1'b0;
        fwd         = 1'b0;

        if (abort) begin
            // Abort wins over everything: back to idle with all outputs low.
            state_d     = ST_IDLE;
            ones_d      = 3'd0;
            cnt_d       = 7'd0;
            stuff_err_d = 1'b0;
            len_err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sop) begin
                        state_d = ST_RECV;
                        ones_d  = 3'd0;
                        cnt_d   = 7'd0;
                    end
                end

                ST_RECV: begin
                    if (sop) begin
                        // A new SYNC restarts reception; the partial packet
                        // is silently discarded.
                        ones_d = 3'd0;
                        cnt_d  = 7'd0;
                    end else begin
                        if (d_valid) begin
                            if (ones_q == ONES_STUF) begin
                                if (d_in) begin
                                    state_d     = ST_ERR;
                                    stuff_err_d = 1'b1;
                                    bit_err     = 1'b1;
                                end else begin
                                    // Stuffed 0: consumed, not forwarded.
                                    ones_d = 3'd0;
                                end
                            end else if (cnt_q == MAX_BITS) begin
                                state_d   = ST_ERR;
                                len_err_d = 1'b1;
                                bit_err   = 1'b1;
                            end else begin
                                fwd       = 1'b1;
                                s_valid_d = 1'b1;
                                s_in_d    = d_in;
                                start_d   = (cnt_q == 7'd0);
                                cnt_d     = cnt_q + 7'd1;
                                ones_d    = d_in ? (ones_q + 3'd1) : 3'd0;
                            end
                        end

                        // End of packet is judged after this cycle's bit.
                        if (eop && !bit_err) begin
                            if (cnt_d != 7'd0) begin
                                state_d = ST_DONE;
                                // If a bit is forwarded this cycle the end
                                // pulse is held off one clock so it never
                                // overlaps s_valid.
                                end_d   = !fwd;
                            end else begin
                                state_d = ST_IDLE;
                                ones_d  = 3'd0;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (end_q) begin
                        state_d = ST_IDLE;
                        ones_d  = 3'd0;
                        cnt_d   = 7'd0;
                    end else begin
                        end_d = 1'b1;
                    end
                end

                ST_ERR: begin
                    if (err_ack) begin
                        state_d     = ST_IDLE;
                        ones_d      = 3'd0;
                        cnt_d       = 7'd0;
                        stuff_err_d = 1'b0;
                        len_err_d   = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ones_q      <= 3'd0;
            cnt_q       <= 7'd0;
            s_in_q      <= 1'b0;
            s_valid_q   <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            stuff_err_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            s_in_q      <= s_in_d;
            s_valid_q   <= s_valid_d;
            start_q     <= start_d;
            end_q       <= end_d;
            stuff_err_q <= stuff_err_d;
            len_err_q   <= len_err_d;
        end
    end

    assign s_in         = s_in_q;
    assign s_valid      = s_valid_q;
    assign start_rc_crc = start_q;
    assign end_rc_crc   = end_q;
    assign stuff_err    = stuff_err_q;
    assign len_err      = len_err_q;

endmodule
`default_nettype wire
